usb_ep_sched: RTL and testbench

- Shares the single USB SIE byte interface (tx: txact/txpop/txval/txcork/txdat/txdat_len; rx: rxact/rxval/rxrdy/rxdat; endpt) between NEP endpoint clients.
- Latches the endpoint at transaction start and steers tx/rx bytes to or from that client.
- Answers NAK (txcork) for endpoints with no data, counts bytes, and signals per-endpoint transaction completion.
- Sits between the SIE and the per-endpoint data blocks (loopback, FIFOs).

---
 rtl/usb_ep_pkg.sv | 15 +
 rtl/usb_ep_mux.sv | 44 ++++
 rtl/usb_ep_sched.sv | 142 ++++++++++++++
 tb/tb_usb_ep_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
// Shared types and defaults for the USB endpoint scheduler.
package usb_ep_pkg;

   localparam int LENW_DEF   = 12;
   localparam int MAXPKT_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TX   = 2'd1,
      ST_RX   = 2'd2
   } state_t;

   typedef logic [LENW_DEF-1:0] ep_len_t;

endpackage

// File: rtl/usb_ep_mux.sv
// NEP-way endpoint selection: one lookup for the live SIE endpoint (NAK/length)
// and one for the latched endpoint (data, ready, one-hot strobe steering).
module usb_ep_mux
   import usb_ep_pkg::*;
#(
   parameter int NEP  = 4,
   parameter int LENW = LENW_DEF
) (
   input  logic [3:0]          idx_a,
   input  logic [3:0]          idx_b,
   input  logic [NEP*LENW-1:0] ep_tx_len,
   input  logic [NEP*8-1:0]    ep_tx_dat,
   input  logic [NEP-1:0]      ep_rx_rdy,
   output logic                valid_a,
   output logic [LENW-1:0]     len_a,
   output logic                valid_b,
   output logic [7:0]          dat_b,
   output logic                rdy_b,
   output logic [NEP-1:0]      onehot_b
);

   // Out-of-range indices fall through with everything zero.
   always_comb begin
      valid_a  = 1'b0;
      len_a    = '0;
      valid_b  = 1'b0;
      dat_b    = '0;
      rdy_b    = 1'b0;
      onehot_b = '0;
      for (int i = 0; i < NEP; i++) begin
         if (idx_a == 4'(i)) begin
            valid_a = 1'b1;
            len_a   = ep_tx_len[i*LENW +: LENW];
         end
         if (idx_b == 4'(i)) begin
            valid_b     = 1'b1;
            dat_b       = ep_tx_dat[i*8 +: 8];
            rdy_b       = ep_rx_rdy[i];
            onehot_b[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_ep_sched.sv
// Shares the SIE byte interface between NEP endpoint clients: latches the endpoint
// at transaction start, steers tx/rx bytes, answers NAK and reports completion.
module usb_ep_sched
   import usb_ep_pkg::*;
#(
   parameter int NEP    = 4,
   parameter int MAXPKT = MAXPKT_DEF,
   parameter int LENW   = LENW_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          endpt,
   input  logic                txact,
   input  logic                txpop,
   output logic                txval,
   output logic                txcork,
   output logic [7:0]          txdat,
   output logic [LENW-1:0]     txdat_len,
   input  logic                rxact,
   input  logic                rxval,
   output logic                rxrdy,
   input  logic [7:0]          rxdat,
   input  logic [NEP*LENW-1:0] ep_tx_len,
   input  logic [NEP*8-1:0]    ep_tx_dat,
   output logic [NEP-1:0]      ep_tx_pop,
   output logic [NEP-1:0]      ep_tx_done,
   output logic [7:0]          ep_rx_dat,
   output logic [NEP-1:0]      ep_rx_val,
   input  logic [NEP-1:0]      ep_rx_rdy,
   output logic [NEP-1:0]      ep_rx_end,
   output logic [LENW-1:0]     ep_rx_cnt
);

   // state   | meaning
   // ST_IDLE | no transaction; NAK flag and IN length track the live endpt
   // ST_TX   | IN transaction on sel; bytes popped until remaining hits 0
   // ST_RX   | OUT transaction on sel; accepted bytes counted (saturating)

   state_t           state, state_nx;
   logic [3:0]       sel;
   logic [LENW-1:0]  remaining;
   logic [LENW-1:0]  count;

   logic             valid_a, valid_b, rdy_b;
   logic [LENW-1:0]  len_a, len_clamp;
   logic [7:0]       dat_b;
   logic [NEP-1:0]   onehot_b;
   logic             pop, acc;

   usb_ep_mux #(.NEP(NEP), .LENW(LENW)) u_mux (
      .idx_a     (endpt),
      .idx_b     (sel),
      .ep_tx_len (ep_tx_len),
      .ep_tx_dat (ep_tx_dat),
      .ep_rx_rdy (ep_rx_rdy),
      .valid_a   (valid_a),
      .len_a     (len_a),
      .valid_b   (valid_b),
      .dat_b     (dat_b),
      .rdy_b     (rdy_b),
      .onehot_b  (onehot_b)
   );

   assign len_clamp = (len_a > LENW'(MAXPKT)) ? LENW'(MAXPKT) : len_a;

   always_comb begin
      state_nx  = state;
      txval     = 1'b0;
      txdat     = '0;
      rxrdy     = 1'b0;
      ep_rx_dat = '0;
      pop       = 1'b0;
      acc       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (txact)      state_nx = ST_TX;
            else if (rxact) state_nx = ST_RX;
         end
         ST_TX: begin
            txval = valid_b && (remaining != '0);
            txdat = txval ? dat_b : 8'h00;
            pop   = txval && txpop;
            if (!txact) state_nx = ST_IDLE;
         end
         ST_RX: begin
            // An unknown endpoint still drains the SIE; its bytes go nowhere.
            rxrdy     = valid_b ? rdy_b : 1'b1;
            ep_rx_dat = rxdat;
            acc       = rxact && rxval && rxrdy;
            if (!rxact) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign ep_tx_pop = pop ? onehot_b : '0;
   assign ep_rx_val = acc ? onehot_b : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         sel        <= '0;
         remaining  <= '0;
         count      <= '0;
         txcork     <= 1'b1;
         txdat_len  <= '0;
         ep_tx_done <= '0;
         ep_rx_end  <= '0;
         ep_rx_cnt  <= '0;
      end else begin
         state      <= state_nx;
         ep_tx_done <= '0;
         ep_rx_end  <= '0;
         case (state)
            ST_IDLE: begin
               txcork    <= !valid_a || (len_a == '0);
               txdat_len <= len_clamp;
               if (txact) begin
                  sel       <= endpt;
                  remaining <= len_clamp;
               end else if (rxact) begin
                  sel   <= endpt;
                  count <= '0;
               end
            end
            ST_TX: begin
               if (pop)    remaining  <= remaining - 1'b1;
               if (!txact) ep_tx_done <= onehot_b;
            end
            ST_RX: begin
               if (acc && (count != '1)) count <= count + 1'b1;
               if (!rxact) begin
                  ep_rx_end <= onehot_b;
                  ep_rx_cnt <= count;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_ep_sched.sv
// Directed bench for usb_ep_sched: IN/NAK/clamp/OUT/priority/reset scenarios.
module tb_usb_ep_sched;

   localparam int NEP    = 4;
   localparam int LENW   = 12;
   localparam int MAXPKT = 64;

   logic                clk;
   logic                rst;
   logic [3:0]          endpt;
   logic                txact, txpop, txval, txcork;
   logic [7:0]          txdat;
   logic [LENW-1:0]     txdat_len;
   logic                rxact, rxval, rxrdy;
   logic [7:0]          rxdat;
   logic [NEP*LENW-1:0] ep_tx_len;
   logic [NEP*8-1:0]    ep_tx_dat;
   logic [NEP-1:0]      ep_tx_pop, ep_tx_done, ep_rx_val, ep_rx_rdy, ep_rx_end;
   logic [7:0]          ep_rx_dat;
   logic [LENW-1:0]     ep_rx_cnt;

   int checks = 0;
   int errors = 0;

   usb_ep_sched #(.NEP(NEP), .MAXPKT(MAXPKT), .LENW(LENW)) dut (
      .clk(clk), .rst(rst), .endpt(endpt),
      .txact(txact), .txpop(txpop), .txval(txval), .txcork(txcork),
      .txdat(txdat), .txdat_len(txdat_len),
      .rxact(rxact), .rxval(rxval), .rxrdy(rxrdy), .rxdat(rxdat),
      .ep_tx_len(ep_tx_len), .ep_tx_dat(ep_tx_dat), .ep_tx_pop(ep_tx_pop),
      .ep_tx_done(ep_tx_done), .ep_rx_dat(ep_rx_dat), .ep_rx_val(ep_rx_val),
      .ep_rx_rdy(ep_rx_rdy), .ep_rx_end(ep_rx_end), .ep_rx_cnt(ep_rx_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++; if (txval !== 1'b0) begin errors++; $display("FAIL reset_txval: got %b expected 0", txval); end
      checks++; if (txcork !== 1'b1) begin errors++; $display("FAIL reset_txcork: got %b expected 1", txcork); end
      checks++; if (txdat !== 8'h00) begin errors++; $display("FAIL reset_txdat: got %h expected 00", txdat); end
      checks++; if (txdat_len !== 12'd0) begin errors++; $display("FAIL reset_txdat_len: got %0d expected 0", txdat_len); end
      checks++; if (rxrdy !== 1'b0) begin errors++; $display("FAIL reset_rxrdy: got %b expected 0", rxrdy); end
      checks++; if (ep_rx_dat !== 8'h00) begin errors++; $display("FAIL reset_ep_rx_dat: got %h expected 00", ep_rx_dat); end
      checks++; if (ep_rx_cnt !== 12'd0) begin errors++; $display("FAIL reset_ep_rx_cnt: got %0d expected 0", ep_rx_cnt); end
      checks++; if ({ep_tx_pop, ep_tx_done, ep_rx_val, ep_rx_end} !== 16'h0) begin errors++; $display("FAIL reset_ep_vectors: got %h expected 0000", {ep_tx_pop, ep_tx_done, ep_rx_val, ep_rx_end}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_in_data;
      logic [7:0] b [3];
      int pops;
      b[0] = 8'hA1; b[1] = 8'hA2; b[2] = 8'hA3;
      pops = 0;
      ep_tx_len[1*LENW +: LENW] = 12'd3;
      ep_tx_dat[1*8 +: 8] = b[0];
      endpt = 4'd1;
      tick();
      checks++; if (txcork !== 1'b0) begin errors++; $display("FAIL in_txcork: got %b expected 0", txcork); end
      checks++; if (txdat_len !== 12'd3) begin errors++; $display("FAIL in_txdat_len: got %0d expected 3", txdat_len); end
      txact = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         txpop = 1'b1;
         #1;
         checks++; if (txval !== 1'b1) begin errors++; $display("FAIL in_txval_%0d: got %b expected 1", k, txval); end
         checks++; if (txdat !== b[k]) begin errors++; $display("FAIL in_txdat_%0d: got %h expected %h", k, txdat, b[k]); end
         if (ep_tx_pop === 4'b0010) pops++;
         tick();
         ep_tx_len[1*LENW +: LENW] = ep_tx_len[1*LENW +: LENW] - 12'd1;
         if (k < 2) ep_tx_dat[1*8 +: 8] = b[k+1];
      end
      txpop = 1'b0;
      #1;
      checks++; if (txval !== 1'b0) begin errors++; $display("FAIL in_txval_empty: got %b expected 0", txval); end
      checks++; if (txdat !== 8'h00) begin errors++; $display("FAIL in_txdat_empty: got %h expected 00", txdat); end
      checks++; if (txcork !== 1'b0) begin errors++; $display("FAIL in_txcork_held: got %b expected 0", txcork); end
      checks++; if (pops !== 3) begin errors++; $display("FAIL in_pop_count: got %0d expected 3", pops); end
      txact = 1'b0;
      tick();
      checks++; if (ep_tx_done !== 4'b0010) begin errors++; $display("FAIL in_done: got %b expected 0010", ep_tx_done); end
      tick();
      checks++; if (ep_tx_done !== 4'b0000) begin errors++; $display("FAIL in_done_pulse: got %b expected 0000", ep_tx_done); end
      checks++; if (txcork !== 1'b1) begin errors++; $display("FAIL in_txcork_drained: got %b expected 1", txcork); end
   endtask

   task automatic test_nak;
      endpt = 4'd2;
      ep_tx_len[2*LENW +: LENW] = 12'd0;
      tick();
      checks++; if (txcork !== 1'b1) begin errors++; $display("FAIL nak_txcork: got %b expected 1", txcork); end
      checks++; if (txdat_len !== 12'd0) begin errors++; $display("FAIL nak_txdat_len: got %0d expected 0", txdat_len); end
      txact = 1'b1;
      tick();
      txpop = 1'b1;
      #1;
      checks++; if (txval !== 1'b0) begin errors++; $display("FAIL nak_txval: got %b expected 0", txval); end
      checks++; if (ep_tx_pop !== 4'b0000) begin errors++; $display("FAIL nak_pop: got %b expected 0000", ep_tx_pop); end
      tick();
      txpop = 1'b0;
      txact = 1'b0;
      tick();
      checks++; if (ep_tx_done !== 4'b0100) begin errors++; $display("FAIL nak_done: got %b expected 0100", ep_tx_done); end
      tick();
      endpt = 4'd7;
      ep_tx_len[3*LENW +: LENW] = 12'd5;
      tick();
      checks++; if (txcork !== 1'b1) begin errors++; $display("FAIL oor_txcork: got %b expected 1", txcork); end
      checks++; if (txdat_len !== 12'd0) begin errors++; $display("FAIL oor_txdat_len: got %0d expected 0", txdat_len); end
      txact = 1'b1;
      tick();
      txpop = 1'b1;
      #1;
      checks++; if ({txval, ep_tx_pop} !== 5'b0) begin errors++; $display("FAIL oor_txval_pop: got %b expected 00000", {txval, ep_tx_pop}); end
      tick();
      txpop = 1'b0;
      txact = 1'b0;
      tick();
      checks++; if (ep_tx_done !== 4'b0000) begin errors++; $display("FAIL oor_done: got %b expected 0000", ep_tx_done); end
      ep_tx_len[3*LENW +: LENW] = 12'd0;
      tick();
   endtask

   task automatic test_clamp;
      int pops;
      pops = 0;
      ep_tx_len[0 +: LENW] = 12'd100;
      ep_tx_dat[0 +: 8] = 8'h5A;
      endpt = 4'd0;
      tick();
      checks++; if (txdat_len !== 12'd64) begin errors++; $display("FAIL clamp_len: got %0d expected 64", txdat_len); end
      checks++; if (txcork !== 1'b0) begin errors++; $display("FAIL clamp_txcork: got %b expected 0", txcork); end
      txact = 1'b1;
      tick();
      for (int i = 0; i < 66; i++) begin
         txpop = 1'b1;
         #1;
         if (ep_tx_pop === 4'b0001) pops++;
         if (i >= 64) begin
            checks++; if ({txval, ep_tx_pop} !== 5'b0) begin errors++; $display("FAIL clamp_underflow_%0d: got %b expected 00000", i, {txval, ep_tx_pop}); end
         end
         tick();
      end
      txpop = 1'b0;
      checks++; if (pops !== 64) begin errors++; $display("FAIL clamp_pop_count: got %0d expected 64", pops); end
      txact = 1'b0;
      tick();
      checks++; if (ep_tx_done !== 4'b0001) begin errors++; $display("FAIL clamp_done: got %b expected 0001", ep_tx_done); end
      ep_tx_len[0 +: LENW] = 12'd0;
      tick();
   endtask

   task automatic test_rx_backpressure;
      logic rdy_pat [7];
      int strobes;
      rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b1; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b0;
      rdy_pat[4] = 1'b1; rdy_pat[5] = 1'b1; rdy_pat[6] = 1'b1;
      strobes = 0;
      endpt = 4'd3;
      ep_rx_rdy = 4'hF;
      rxact = 1'b1;
      tick();
      for (int k = 0; k < 7; k++) begin
         ep_rx_rdy[3] = rdy_pat[k];
         rxval = 1'b1;
         rxdat = 8'(8'h10 + k);
         #1;
         checks++; if (rxrdy !== rdy_pat[k]) begin errors++; $display("FAIL rx_rdy_%0d: got %b expected %b", k, rxrdy, rdy_pat[k]); end
         checks++; if (ep_rx_val !== (rdy_pat[k] ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL rx_val_%0d: got %b expected %b", k, ep_rx_val, rdy_pat[k] ? 4'b1000 : 4'b0000); end
         checks++; if (ep_rx_dat !== 8'(8'h10 + k)) begin errors++; $display("FAIL rx_dat_%0d: got %h expected %h", k, ep_rx_dat, 8'(8'h10 + k)); end
         if (ep_rx_val[3] === 1'b1) strobes++;
         tick();
      end
      rxval = 1'b0;
      rxact = 1'b0;
      tick();
      checks++; if (ep_rx_end !== 4'b1000) begin errors++; $display("FAIL rx_end: got %b expected 1000", ep_rx_end); end
      checks++; if (ep_rx_cnt !== 12'd5) begin errors++; $display("FAIL rx_cnt: got %0d expected 5", ep_rx_cnt); end
      checks++; if (strobes !== 5) begin errors++; $display("FAIL rx_strobe_count: got %0d expected 5", strobes); end
      ep_rx_rdy = 4'hF;
      tick();
      checks++; if (ep_rx_end !== 4'b0000) begin errors++; $display("FAIL rx_end_pulse: got %b expected 0000", ep_rx_end); end
   endtask

   task automatic test_priority;
      ep_tx_len[1*LENW +: LENW] = 12'd2;
      ep_tx_dat[1*8 +: 8] = 8'hB1;
      endpt = 4'd1;
      tick();
      txact = 1'b1;
      rxact = 1'b1;
      tick();
      checks++; if ({txval, rxrdy} !== 2'b10) begin errors++; $display("FAIL prio_tx_taken: got txval/rxrdy %b expected 10", {txval, rxrdy}); end
      rxact = 1'b0;
      endpt = 4'd2;
      txpop = 1'b1;
      #1;
      checks++; if (ep_tx_pop !== 4'b0010) begin errors++; $display("FAIL prio_pop0: got %b expected 0010", ep_tx_pop); end
      tick();
      ep_tx_dat[1*8 +: 8] = 8'hB2;
      #1;
      checks++; if (txdat !== 8'hB2) begin errors++; $display("FAIL prio_txdat1: got %h expected b2", txdat); end
      checks++; if (ep_tx_pop !== 4'b0010) begin errors++; $display("FAIL prio_pop1: got %b expected 0010", ep_tx_pop); end
      tick();
      txpop = 1'b0;
      #1;
      checks++; if (txval !== 1'b0) begin errors++; $display("FAIL prio_txval_end: got %b expected 0", txval); end
      txact = 1'b0;
      tick();
      checks++; if (ep_tx_done !== 4'b0010) begin errors++; $display("FAIL prio_done: got %b expected 0010", ep_tx_done); end
      ep_tx_len[1*LENW +: LENW] = 12'd0;
      tick();
   endtask

   task automatic test_reset_mid_tx;
      int pops;
      pops = 0;
      ep_tx_len[2*LENW +: LENW] = 12'd4;
      ep_tx_dat[2*8 +: 8] = 8'hC1;
      endpt = 4'd2;
      tick();
      txact = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
         txpop = 1'b1;
         #1;
         checks++; if (ep_tx_pop !== 4'b0100) begin errors++; $display("FAIL rmt_pop_%0d: got %b expected 0100", k, ep_tx_pop); end
         tick();
      end
      txpop = 1'b0;
      rst = 1'b1;
      tick();
      checks++; if ({txval, txcork, txdat} !== 10'b01_0000_0000) begin errors++; $display("FAIL rmt_tx_outputs: got %b expected 0100000000", {txval, txcork, txdat}); end
      checks++; if (txdat_len !== 12'd0) begin errors++; $display("FAIL rmt_txdat_len: got %0d expected 0", txdat_len); end
      checks++; if ({ep_tx_pop, ep_tx_done} !== 8'h00) begin errors++; $display("FAIL rmt_vectors: got %b expected 00000000", {ep_tx_pop, ep_tx_done}); end
      txact = 1'b0;
      tick();
      checks++; if (ep_tx_done !== 4'b0000) begin errors++; $display("FAIL rmt_no_done_a: got %b expected 0000", ep_tx_done); end
      rst = 1'b0;
      tick();
      checks++; if (ep_tx_done !== 4'b0000) begin errors++; $display("FAIL rmt_no_done_b: got %b expected 0000", ep_tx_done); end
      checks++; if ({txcork, txdat_len} !== {1'b0, 12'd4}) begin errors++; $display("FAIL rmt_restart_len: got cork %b len %0d expected cork 0 len 4", txcork, txdat_len); end
      txact = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         txpop = 1'b1;
         #1;
         if (ep_tx_pop === 4'b0100) pops++;
         tick();
      end
      txpop = 1'b0;
      checks++; if (pops !== 4) begin errors++; $display("FAIL rmt_pop_count: got %0d expected 4", pops); end
      txact = 1'b0;
      tick();
      checks++; if (ep_tx_done !== 4'b0100) begin errors++; $display("FAIL rmt_done: got %b expected 0100", ep_tx_done); end
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      endpt     = 4'd0;
      txact     = 1'b0;
      txpop     = 1'b0;
      rxact     = 1'b0;
      rxval     = 1'b0;
      rxdat     = 8'h00;
      ep_tx_len = '0;
      ep_tx_dat = '0;
      ep_rx_rdy = 4'hF;
      test_reset();
      test_in_data();
      test_nak();
      test_clamp();
      test_rx_backpressure();
      test_priority();
      test_reset_mid_tx();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
